// File: rtl/opram_sequencer_if.sv
// Bundle of loader, fetch/core and RAM-macro signals around the op RAM sequencer.
// master is the sequencer's view; slave is the view of the surrounding loader, core and RAM.
interface opram_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              run;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              op_valid;
    logic [DATA_W-1:0] op;
    logic [ADDR_W-1:0] op_pc;
    logic              op_ready;
    logic              busy;
    logic              ram_ce;
    logic              ram_wre;
    logic              ram_oce;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        input  ld_valid, ld_addr, ld_data, run, jump, jump_addr, op_ready, ram_dout,
        output ld_ready, op_valid, op, op_pc, busy, ram_ce, ram_wre, ram_oce, ram_ad, ram_din
    );

    modport slave (
        output ld_valid, ld_addr, ld_data, run, jump, jump_addr, op_ready, ram_dout,
        input  ld_ready, op_valid, op, op_pc, busy, ram_ce, ram_wre, ram_oce, ram_ad, ram_din
    );
endinterface

// File: rtl/opram_sequencer.sv
// Shares a single-port op RAM between a program loader and instruction fetch,
// keeping the fetch pc, one outstanding access, jump flush and a valid/ready op output.
module opram_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    opram_sequencer_if.master bus
);
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_n;
    logic              ram_ce_q, ram_wre_q, ram_oce_q, op_valid_q;
    logic              ram_ce_n, ram_wre_n, ram_oce_n, op_valid_n;
    logic [ADDR_W-1:0] ram_ad_q, ram_ad_n, op_pc_q, op_pc_n;
    logic [DATA_W-1:0] ram_din_q, ram_din_n, op_q, op_n;
    logic              consume;
    logic              last_wait;
    logic              flush;

    assign consume   = (state == HOLD) && bus.op_ready;
    assign last_wait = (state == WAIT) && (wait_cnt == CNT_W'(READ_LAT - 1));
    assign flush     = bus.jump && ((state == READ) || (state == WAIT) || (state == HOLD));

    // A jump in the consume cycle redirects to IDLE, so the loader is not taken then.
    assign bus.ld_ready = (state == IDLE) || (consume && !bus.jump);
    assign bus.busy     = (state != IDLE);

    assign bus.op_valid = op_valid_q;
    assign bus.op       = op_q;
    assign bus.op_pc    = op_pc_q;
    assign bus.ram_ce   = ram_ce_q;
    assign bus.ram_wre  = ram_wre_q;
    assign bus.ram_oce  = ram_oce_q;
    assign bus.ram_ad   = ram_ad_q;
    assign bus.ram_din  = ram_din_q;

    // Jump target wins over the post-consume increment.
    always_comb begin
        pc_n = pc;
        if (consume) pc_n = pc + ADDR_W'(1);
        if (bus.jump) pc_n = bus.jump_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.ld_valid) state_n = WRITE;
                else if (bus.run) state_n = READ;
            end
            WRITE: state_n = IDLE;
            READ:  state_n = WAIT;
            WAIT:  if (last_wait) state_n = HOLD;
            HOLD: begin
                if (consume) begin
                    if (bus.ld_valid) state_n = WRITE;
                    else if (bus.run) state_n = READ;
                    else              state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        ram_ce_n   = 1'b0;
        ram_wre_n  = 1'b0;
        ram_oce_n  = 1'b0;
        op_valid_n = 1'b0;
        ram_ad_n   = ram_ad_q;
        ram_din_n  = ram_din_q;
        op_n       = op_q;
        op_pc_n    = op_pc_q;
        wait_cnt_n = '0;
        case (state_n)
            WRITE: begin
                ram_ce_n  = 1'b1;
                ram_wre_n = 1'b1;
                ram_ad_n  = bus.ld_addr;
                ram_din_n = bus.ld_data;
            end
            READ: begin
                ram_ce_n = 1'b1;
                ram_ad_n = pc_n;
            end
            WAIT: begin
                ram_ce_n   = 1'b1;
                ram_oce_n  = 1'b1;
                wait_cnt_n = (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            end
            HOLD:    op_valid_n = 1'b1;
            default: ;
        endcase
        // ram_ad still holds the fetch address during WAIT.
        if ((state == WAIT) && (state_n == HOLD)) begin
            op_n    = bus.ram_dout;
            op_pc_n = ram_ad_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            wait_cnt   <= '0;
            ram_ce_q   <= 1'b0;
            ram_wre_q  <= 1'b0;
            ram_oce_q  <= 1'b0;
            ram_ad_q   <= '0;
            ram_din_q  <= '0;
            op_valid_q <= 1'b0;
            op_q       <= '0;
            op_pc_q    <= '0;
        end else begin
            pc         <= pc_n;
            wait_cnt   <= wait_cnt_n;
            ram_ce_q   <= ram_ce_n;
            ram_wre_q  <= ram_wre_n;
            ram_oce_q  <= ram_oce_n;
            ram_ad_q   <= ram_ad_n;
            ram_din_q  <= ram_din_n;
            op_valid_q <= op_valid_n;
            op_q       <= op_n;
            op_pc_q    <= op_pc_n;
        end
    end
endmodule

// File: tb/tb_opram_sequencer.sv
// Bench for opram_sequencer: a behavioural RAM plus a shadow memory and expected pc
// predict every fetched op; each task drives one scenario and checks it inline.
`timescale 1ns/1ps
module tb_opram_sequencer;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned READ_LAT = 2;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   wre_cnt = 0;
    int   exp_pc = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH];

    opram_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    opram_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM macro: address registered on ce, output register loaded on oce (2-cycle read).
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_stage;
    always @(posedge clk) begin
        if (bus.ram_ce && bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
        if (bus.ram_ce && !bus.ram_wre) ram_stage <= mem[bus.ram_ad];
        if (bus.ram_ce && bus.ram_oce) bus.ram_dout <= ram_stage;
    end

    always @(negedge clk) if (bus.ram_wre) wre_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.op_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_oce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.ram_oce) begin ok = 1'b1; break; end
            step();
        end
    endtask

    // Waits for an op, captures it and consumes it with op_ready high.
    task automatic take_op(output bit ok, output logic [DATA_W-1:0] o, output logic [ADDR_W-1:0] p);
        o = '0;
        p = '0;
        wait_valid(ok);
        if (ok) begin
            o = bus.op;
            p = bus.op_pc;
            bus.op_ready = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++;
        if ({bus.op_valid, bus.op, bus.op_pc, bus.ram_ce, bus.ram_wre, bus.ram_oce,
             bus.ram_ad, bus.ram_din, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b op=%h pc=%h ce=%b wre=%b oce=%b ad=%h din=%h busy=%b, want all 0",
                     bus.op_valid, bus.op, bus.op_pc, bus.ram_ce, bus.ram_wre, bus.ram_oce,
                     bus.ram_ad, bus.ram_din, bus.busy);
        end
        total++;
        if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
        @(negedge clk);
        rst = 1'b1;
        step();
        exp_pc = 0;
    endtask

    task automatic test_load();
        int w0;
        w0 = wre_cnt;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = ADDR_W'(i);
            bus.ld_data  = DATA_W'(8'hA0 + i);
            #1;
            total++;
            if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready_hi[%0d]: got %b want 1", i, bus.ld_ready); end
            step();
            exp_mem[i] = DATA_W'(8'hA0 + i);
            total++;
            if ({bus.ram_ce, bus.ram_wre, bus.ram_oce, bus.ram_ad, bus.ram_din} !==
                {1'b1, 1'b1, 1'b0, ADDR_W'(i), exp_mem[i]}) begin
                bad++;
                $display("FAIL load_write[%0d]: got ce=%b wre=%b oce=%b ad=%h din=%h want 1 1 0 %h %h",
                         i, bus.ram_ce, bus.ram_wre, bus.ram_oce, bus.ram_ad, bus.ram_din, i, exp_mem[i]);
            end
            total++;
            if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL load_ready_lo[%0d]: got %b want 0", i, bus.ld_ready); end
            step();
        end
        bus.ld_valid = 1'b0;
        total++;
        if (wre_cnt - w0 != int'(DEPTH)) begin bad++; $display("FAIL load_wre_count: got %0d want %0d", wre_cnt - w0, DEPTH); end
    endtask

    task automatic test_fetch();
        int lat;
        bit ok;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        bus.op_ready = 1'b1;
        bus.run = 1'b1;
        step();
        total++;
        if ({bus.ram_ce, bus.ram_wre, bus.ram_ad} !== {1'b1, 1'b0, ADDR_W'(exp_pc)}) begin
            bad++;
            $display("FAIL fetch_first_read: got ce=%b wre=%b ad=%h want 1 0 %h", bus.ram_ce, bus.ram_wre, bus.ram_ad, exp_pc);
        end
        lat = 0;
        while (!bus.op_valid && lat < 12) begin step(); lat++; end
        total++;
        if (lat != int'(READ_LAT) + 1) begin bad++; $display("FAIL fetch_latency: got %0d want %0d", lat, READ_LAT + 1); end
        for (int k = 0; k < 10; k++) begin
            take_op(ok, o, p);
            total++;
            if (!ok || p !== ADDR_W'(exp_pc) || o !== exp_mem[exp_pc]) begin
                bad++;
                $display("FAIL fetch_op[%0d]: got ok=%b pc=%h op=%h want pc=%h op=%h", k, ok, p, o, exp_pc, exp_mem[exp_pc]);
            end
            exp_pc = (exp_pc + 1) % int'(DEPTH);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int len;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        for (int k = 0; k < 3; k++) begin
            len = (k == 0) ? 5 : int'($urandom_range(1, 6));
            bus.op_ready = 1'b0;
            wait_valid(ok);
            o = bus.op;
            p = bus.op_pc;
            total++;
            if (!ok || p !== ADDR_W'(exp_pc) || o !== exp_mem[exp_pc]) begin
                bad++;
                $display("FAIL stall_op[%0d]: got ok=%b pc=%h op=%h want pc=%h op=%h", k, ok, p, o, exp_pc, exp_mem[exp_pc]);
            end
            for (int c = 0; c < len; c++) begin
                step();
                total++;
                if (bus.op_valid !== 1'b1 || bus.op !== o || bus.op_pc !== p || bus.ram_ce !== 1'b0 || bus.ld_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold[%0d.%0d]: got valid=%b op=%h pc=%h ce=%b ld_ready=%b want 1 %h %h 0 0",
                             k, c, bus.op_valid, bus.op, bus.op_pc, bus.ram_ce, bus.ld_ready, o, p);
                end
            end
            bus.op_ready = 1'b1;
            #1;
            total++;
            if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL stall_consume_ld_ready[%0d]: got %b want 1", k, bus.ld_ready); end
            step();
            exp_pc = (exp_pc + 1) % int'(DEPTH);
            total++;
            if ({bus.ram_ce, bus.ram_wre, bus.ram_ad} !== {1'b1, 1'b0, ADDR_W'(exp_pc)}) begin
                bad++;
                $display("FAIL stall_next_read[%0d]: got ce=%b wre=%b ad=%h want 1 0 %h", k, bus.ram_ce, bus.ram_wre, bus.ram_ad, exp_pc);
            end
        end
    endtask

    task automatic test_jump_wait();
        bit ok;
        int tgt;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        for (int k = 0; k < 3; k++) begin
            tgt = (k == 0) ? 5 : int'($urandom_range(0, DEPTH - 1));
            wait_oce(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL jump_wait_reach[%0d]: got no WAIT want ram_oce=1", k); end
            bus.jump = 1'b1;
            bus.jump_addr = ADDR_W'(tgt);
            step();
            bus.jump = 1'b0;
            total++;
            if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL jump_wait_flush[%0d]: got valid=%b busy=%b want 0 0", k, bus.op_valid, bus.busy);
            end
            exp_pc = tgt;
            take_op(ok, o, p);
            total++;
            if (!ok || p !== ADDR_W'(exp_pc) || o !== exp_mem[exp_pc]) begin
                bad++;
                $display("FAIL jump_wait_op[%0d]: got ok=%b pc=%h op=%h want pc=%h op=%h", k, ok, p, o, exp_pc, exp_mem[exp_pc]);
            end
            exp_pc = (exp_pc + 1) % int'(DEPTH);
        end
    endtask

    task automatic test_jump_consume();
        bit ok;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        for (int i = 0; i < int'(DEPTH) && exp_pc != 6; i++) begin
            take_op(ok, o, p);
            exp_pc = (exp_pc + 1) % int'(DEPTH);
        end
        wait_valid(ok);
        total++;
        if (!ok || bus.op_pc !== ADDR_W'(6)) begin
            bad++;
            $display("FAIL jc_reach6: got ok=%b pc=%h want pc=6", ok, bus.op_pc);
        end
        bus.jump = 1'b1;
        bus.jump_addr = ADDR_W'(2);
        step();
        bus.jump = 1'b0;
        total++;
        if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL jc_dropped: got valid=%b want 0", bus.op_valid); end
        exp_pc = 2;
        take_op(ok, o, p);
        total++;
        if (!ok || p !== ADDR_W'(exp_pc) || o !== exp_mem[exp_pc]) begin
            bad++;
            $display("FAIL jc_next: got ok=%b pc=%h op=%h want pc=%h op=%h", ok, p, o, exp_pc, exp_mem[exp_pc]);
        end
        exp_pc = (exp_pc + 1) % int'(DEPTH);
    endtask

    task automatic test_ld_in_hold();
        bit ok;
        int addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        for (int k = 0; k < 3; k++) begin
            bus.op_ready = 1'b0;
            wait_valid(ok);
            addr = (exp_pc + 1) % int'(DEPTH);
            data = DATA_W'($urandom);
            bus.ld_valid = 1'b1;
            bus.ld_addr  = ADDR_W'(addr);
            bus.ld_data  = data;
            #1;
            total++;
            if (!ok || bus.ld_ready !== 1'b0) begin
                bad++;
                $display("FAIL ldh_blocked[%0d]: got ok=%b ld_ready=%b want 1 0", k, ok, bus.ld_ready);
            end
            bus.op_ready = 1'b1;
            #1;
            total++;
            if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL ldh_accept[%0d]: got %b want 1", k, bus.ld_ready); end
            step();
            bus.ld_valid = 1'b0;
            exp_mem[addr] = data;
            exp_pc = addr;
            total++;
            if ({bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.ram_din} !== {1'b1, 1'b1, ADDR_W'(addr), data}) begin
                bad++;
                $display("FAIL ldh_write[%0d]: got ce=%b wre=%b ad=%h din=%h want 1 1 %h %h",
                         k, bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.ram_din, addr, data);
            end
            step();
            step();
            total++;
            if ({bus.ram_ce, bus.ram_wre, bus.ram_ad} !== {1'b1, 1'b0, ADDR_W'(addr)}) begin
                bad++;
                $display("FAIL ldh_read[%0d]: got ce=%b wre=%b ad=%h want 1 0 %h", k, bus.ram_ce, bus.ram_wre, bus.ram_ad, addr);
            end
            take_op(ok, o, p);
            total++;
            if (!ok || p !== ADDR_W'(addr) || o !== data) begin
                bad++;
                $display("FAIL ldh_op[%0d]: got ok=%b pc=%h op=%h want pc=%h op=%h", k, ok, p, o, addr, data);
            end
            exp_pc = (addr + 1) % int'(DEPTH);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        logic [DATA_W-1:0] o;
        logic [ADDR_W-1:0] p;
        bus.run = 1'b1;
        bus.op_ready = 1'b1;
        wait_oce(ok);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (!ok || {bus.op_valid, bus.op, bus.op_pc, bus.ram_ce, bus.ram_wre, bus.ram_oce,
                    bus.ram_ad, bus.ram_din, bus.busy, bus.ld_ready} !== {{(2 + DATA_W * 2 + ADDR_W * 2 + 4){1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: got ok=%b valid=%b op=%h pc=%h ce=%b wre=%b oce=%b ad=%h din=%h busy=%b ld_ready=%b want zeros, ld_ready=1",
                     ok, bus.op_valid, bus.op, bus.op_pc, bus.ram_ce, bus.ram_wre, bus.ram_oce,
                     bus.ram_ad, bus.ram_din, bus.busy, bus.ld_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        exp_pc = 0;
        take_op(ok, o, p);
        total++;
        if (!ok || p !== ADDR_W'(exp_pc) || o !== exp_mem[exp_pc]) begin
            bad++;
            $display("FAIL post_reset_op: got ok=%b pc=%h op=%h want pc=%h op=%h", ok, p, o, exp_pc, exp_mem[exp_pc]);
        end
        bus.run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        ram_stage     = '0;
        bus.ram_dout  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.run       = 1'b0;
        bus.jump      = 1'b0;
        bus.jump_addr = '0;
        bus.op_ready  = 1'b0;
        test_reset();
        test_load();
        test_fetch();
        test_stall();
        test_jump_wait();
        test_jump_consume();
        test_ld_in_hold();
        test_reset_mid_wait();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
